// File: rtl/bicubic_pkg.sv
// rtl/bicubic_pkg.sv - shared constants and state encoding for the bicubic phase generator
package bicubic_pkg;

  localparam int COEFF_ONE  = 256;
  localparam int COEFF_HALF = 128;
  localparam int FRAC_W     = 8;
  localparam int ACC_W      = 24;
  localparam int COORD_W    = 13;
  localparam int STEP_W     = 9;
  localparam int DIM_W      = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/bicubic_phase_gen_if.sv
// rtl/bicubic_phase_gen_if.sv - phase sample stream between generator and kernel-weight stage
interface bicubic_phase_gen_if;
  import bicubic_pkg::*;

  logic                      out_valid;
  logic                      out_ready;
  logic signed [COORD_W-1:0] x_int;
  logic [8:0]                xBlend;
  logic signed [COORD_W-1:0] y_int;
  logic [8:0]                yBlend;
  logic                      sol;
  logic                      eof;

  modport master (
    output out_valid, x_int, xBlend, y_int, yBlend, sol, eof,
    input  out_ready
  );

  modport slave (
    input  out_valid, x_int, xBlend, y_int, yBlend, sol, eof,
    output out_ready
  );

endinterface

// File: rtl/bicubic_phase_acc.sv
// rtl/bicubic_phase_acc.sv - Q8 source-position accumulator split into integer and fraction
module bicubic_phase_acc
  import bicubic_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic                      advance,
  input  logic [STEP_W-1:0]         step,
  output logic signed [COORD_W-1:0] coord_int,
  output logic [8:0]                coord_frac
);

  localparam logic signed [ACC_W-1:0] HALF_PIX = ACC_W'(COEFF_HALF);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] step_ext;
  logic signed [ACC_W-1:0] init_val;

  // Centre-aligned mapping: the first sample sits at step/2 - half a source pixel.
  assign step_ext = signed'({{(ACC_W-STEP_W){1'b0}}, step});
  assign init_val = (step_ext >>> 1) - HALF_PIX;

  // Load takes priority so an end-of-line reload wins over the per-pixel advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (load) begin
      acc <= init_val;
    end else if (advance) begin
      acc <= acc + step_ext;
    end
  end

  // Bits FRAC_W.. of the accumulator are the arithmetic-shifted integer part.
  assign coord_int  = acc[FRAC_W +: COORD_W];
  assign coord_frac = {1'b0, acc[FRAC_W-1:0]};

endmodule

// File: rtl/bicubic_phase_gen.sv
// rtl/bicubic_phase_gen.sv - raster-order source phase generator for bicubic scaling
module bicubic_phase_gen
  import bicubic_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [DIM_W-1:0]   out_width,
  input  logic [DIM_W-1:0]   out_height,
  input  logic [STEP_W-1:0]  step,
  output logic               busy,
  output logic               done,
  bicubic_phase_gen_if.master pix
);

  state_t state_q, state_d;

  logic [DIM_W-1:0]  width_q, height_q;
  logic [STEP_W-1:0] step_q;
  logic [DIM_W-1:0]  col_q, row_q;
  logic              done_q;

  logic [STEP_W-1:0] step_eff;
  logic [STEP_W-1:0] acc_step;
  logic              cfg_zero, accept, begin_frame;
  logic              fire, last_col, last_row, eol_fire;

  // A step of zero means unity scaling.
  assign step_eff    = (step == '0) ? STEP_W'(COEFF_ONE) : step;
  assign cfg_zero    = (out_width == '0) || (out_height == '0);
  assign accept      = (state_q == ST_IDLE) && start;
  assign begin_frame = accept && !cfg_zero;

  assign last_col = (col_q == width_q - 1'b1);
  assign last_row = (row_q == height_q - 1'b1);
  assign fire     = pix.out_valid && pix.out_ready;
  assign eol_fire = fire && last_col;

  assign pix.out_valid = (state_q == ST_RUN);
  assign pix.sol       = pix.out_valid && (col_q == '0);
  assign pix.eof       = pix.out_valid && last_col && last_row;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;

  // Accumulators are loaded in the start cycle before step_q holds the new step.
  assign acc_step = (state_q == ST_IDLE) ? step_eff : step_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (begin_frame)       state_d = ST_RUN;
      ST_RUN:   if (fire && pix.eof)   state_d = ST_FLUSH;
      ST_FLUSH:                        state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // Configuration latch, raster counters and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_q  <= '0;
      height_q <= '0;
      step_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (accept && cfg_zero) || (fire && pix.eof);
      if (accept) begin
        width_q  <= out_width;
        height_q <= out_height;
        step_q   <= step_eff;
        col_q    <= '0;
        row_q    <= '0;
      end else if (fire) begin
        if (last_col) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  bicubic_phase_acc u_acc_x (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (begin_frame || eol_fire),
    .advance    (fire),
    .step       (acc_step),
    .coord_int  (pix.x_int),
    .coord_frac (pix.xBlend)
  );

  bicubic_phase_acc u_acc_y (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (begin_frame),
    .advance    (eol_fire),
    .step       (acc_step),
    .coord_int  (pix.y_int),
    .coord_frac (pix.yBlend)
  );

endmodule

// File: tb/tb_bicubic_phase_gen.sv
// tb/tb_bicubic_phase_gen.sv - directed self-checking bench for bicubic_phase_gen
module tb_bicubic_phase_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] out_width;
  logic [11:0] out_height;
  logic [8:0]  step;
  logic        busy;
  logic        done;

  bicubic_phase_gen_if pix ();

  bicubic_phase_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .out_width  (out_width),
    .out_height (out_height),
    .step       (step),
    .busy       (busy),
    .done       (done),
    .pix        (pix)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int exp_n;
  int ex_x[8], ex_xb[8], ex_y[8], ex_yb[8], ex_sol[8], ex_eof[8];

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic load_frame_a();
    exp_n = 8;
    ex_x   = '{-1, 0, 0, 1, -1, 0, 0, 1};
    ex_xb  = '{192, 64, 192, 64, 192, 64, 192, 64};
    ex_y   = '{-1, -1, -1, -1, 0, 0, 0, 0};
    ex_yb  = '{192, 192, 192, 192, 64, 64, 64, 64};
    ex_sol = '{1, 0, 0, 0, 1, 0, 0, 0};
    ex_eof = '{0, 0, 0, 0, 0, 0, 0, 1};
  endtask

  task automatic begin_frame(input int w, input int h, input int s);
    @(negedge clk);
    out_width  = 12'(w);
    out_height = 12'(h);
    step       = 9'(s);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"},  pix.out_valid, 0);
    chk({tag, "_sol"},    pix.sol, 0);
    chk({tag, "_eof"},    pix.eof, 0);
    chk({tag, "_busy"},   busy, 0);
    chk({tag, "_done"},   done, 0);
    chk({tag, "_x_int"},  $signed(pix.x_int), 0);
    chk({tag, "_xBlend"}, pix.xBlend, 0);
    chk({tag, "_y_int"},  $signed(pix.y_int), 0);
    chk({tag, "_yBlend"}, pix.yBlend, 0);
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0,1 repeating.
  // start_at >= 0 injects a start pulse with a different configuration mid-frame.
  task automatic collect(input int mode, input int stop_after, input int start_at);
    int  k = 0;
    int  c = 0;
    bit  fin = 0;
    bit  rdy;
    while (!fin && c < 200) begin
      rdy = (mode == 0) || (c % 4 == 0) || (c % 4 == 3);
      pix.out_ready = rdy;
      if (c == start_at) begin
        start = 1'b1; out_width = 12'd2; out_height = 12'd1; step = 9'd256;
      end else begin
        start = 1'b0;
      end
      chk($sformatf("valid_p%0d", k), pix.out_valid, 1);
      if (pix.out_valid && k < exp_n) begin
        chk($sformatf("x_int_p%0d", k),  $signed(pix.x_int), ex_x[k]);
        chk($sformatf("xBlend_p%0d", k), pix.xBlend, ex_xb[k]);
        chk($sformatf("y_int_p%0d", k),  $signed(pix.y_int), ex_y[k]);
        chk($sformatf("yBlend_p%0d", k), pix.yBlend, ex_yb[k]);
        chk($sformatf("sol_p%0d", k),    pix.sol, ex_sol[k]);
        chk($sformatf("eof_p%0d", k),    pix.eof, ex_eof[k]);
        chk($sformatf("busy_p%0d", k),   busy, 1);
        if (rdy) begin
          k++;
          if (k == stop_after) fin = 1;
        end
      end
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    pix.out_ready = 1'b1;
    chk("transfer_count", k, stop_after);
  endtask

  task automatic post_frame(input string tag);
    chk({tag, "_flush_valid"}, pix.out_valid, 0);
    chk({tag, "_flush_done"},  done, 1);
    chk({tag, "_flush_busy"},  busy, 1);
    @(negedge clk);
    chk({tag, "_idle_done"},   done, 0);
    chk({tag, "_idle_busy"},   busy, 0);
    chk({tag, "_idle_valid"},  pix.out_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    out_width = 12'd4;
    out_height = 12'd2;
    step = 9'd128;
    pix.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // x2 frame, ready always high; first valid one cycle after start
    load_frame_a();
    begin_frame(4, 2, 128);
    chk("a_first_valid", pix.out_valid, 1);
    collect(0, 8, -1);
    post_frame("a");

    // Same frame with back-pressure
    begin_frame(4, 2, 128);
    collect(1, 8, -1);
    post_frame("stall");

    // Zero width: done pulse only
    begin_frame(0, 2, 128);
    chk("w0_done", done, 1);
    chk("w0_valid", pix.out_valid, 0);
    chk("w0_busy", busy, 0);
    @(negedge clk);
    chk("w0_done_clear", done, 0);
    chk("w0_valid_after", pix.out_valid, 0);

    // step 0 behaves as unity
    exp_n = 2;
    ex_x = '{0, 1, 0, 0, 0, 0, 0, 0};
    ex_xb = '{0, 0, 0, 0, 0, 0, 0, 0};
    ex_y = '{0, 0, 0, 0, 0, 0, 0, 0};
    ex_yb = '{0, 0, 0, 0, 0, 0, 0, 0};
    ex_sol = '{1, 0, 0, 0, 0, 0, 0, 0};
    ex_eof = '{0, 1, 0, 0, 0, 0, 0, 0};
    begin_frame(2, 1, 0);
    collect(0, 2, -1);
    post_frame("s0");

    // Asynchronous reset at pixel 3, then a clean rerun
    load_frame_a();
    begin_frame(4, 2, 128);
    collect(0, 3, -1);
    chk("mid_p3_x_int", $signed(pix.x_int), 1);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    begin_frame(4, 2, 128);
    collect(0, 8, -1);
    post_frame("rerun");

    // Start and new configuration mid-frame are ignored
    begin_frame(4, 2, 128);
    collect(0, 8, 2);
    post_frame("midstart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bicubic_phase_gen.md
BICUBIC_PHASE_GEN -- requirements
Module: bicubic_phase_gen

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port start, input, 1 bit: one-cycle frame start request.
REQ-004 SHALL have port out_width, input, 12 bits: output pixels per line, unsigned.
REQ-005 SHALL have port out_height, input, 12 bits: output lines per frame, unsigned.
REQ-006 SHALL have port step, input, 9 bits: source increment per output pixel or line, unsigned Q8; x2 scaling = 128.
REQ-007 SHALL have port out_ready, input, 1 bit: downstream (kernel-weight stage) accepts the current output.
REQ-008 SHALL have port out_valid, output, 1 bit: the phase outputs hold a valid sample.
REQ-009 SHALL have port x_int, output, 13 bits, signed: integer source column.
REQ-010 SHALL have port xBlend, output, 9 bits: fractional source column, Q8, range 0..255, feeds the kernel stage xBlend input.
REQ-011 SHALL have port y_int, output, 13 bits, signed: integer source row.
REQ-012 SHALL have port yBlend, output, 9 bits: fractional source row, Q8, range 0..255.
REQ-013 SHALL have port sol, output, 1 bit: marks the first pixel of a line.
REQ-014 SHALL have port eof, output, 1 bit: marks the last pixel of a frame.
REQ-015 SHALL have port busy, output, 1 bit: frame in progress.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse when a frame finishes.

Function
REQ-017 SHALL implement three states, IDLE, RUN and FLUSH; reset enters IDLE.
REQ-018 In IDLE, start SHALL latch out_width, out_height and step and enter RUN; a step value of 0 SHALL be latched as 256.
REQ-019 In IDLE, start with a latched out_width = 0 or out_height = 0 SHALL stay in IDLE and pulse done in the next cycle, with no outputs.
REQ-020 The x and y accumulators SHALL be 24-bit signed Q8 values initialised to step/2 - 128 (centre-aligned mapping): pos(n) = n*step + step/2 - 128.
REQ-021 x_int SHALL equal accumulator arithmetic-shift-right 8 and xBlend SHALL equal {1'b0, acc[7:0]}; y_int and yBlend SHALL use the same rule.
REQ-022 The first out_valid SHALL rise exactly 1 cycle after start is accepted.
REQ-023 Handshake: a sample transfers when out_valid && out_ready; while out_valid && !out_ready, every output SHALL hold stable.
REQ-024 Each transfer SHALL advance the x accumulator by step; the transfer of the last pixel of a line SHALL reload x to its initial value and advance y by step.
REQ-025 sol SHALL be 1 when column = 0; eof SHALL be 1 when column = out_width-1 and row = out_height-1.
REQ-026 The transfer with eof SHALL move the block to FLUSH, drop out_valid, pulse done for 1 cycle, then return to IDLE.
REQ-027 start SHALL be ignored while busy; busy SHALL be 1 in RUN and FLUSH.
REQ-028 Configuration inputs SHALL have no effect mid-frame; only their latched copies are used.

Reset
REQ-029 With rst_n low, the block SHALL go to IDLE immediately (asynchronously), even mid-frame.
REQ-030 On reset, out_valid, sol, eof, busy, done, x_int, y_int, xBlend, yBlend and both accumulators SHALL all be 0.

Structure
REQ-031 Shared package bicubic_pkg SHALL hold COEFF_ONE=256, COEFF_HALF=128, Q8 fraction width 8, ACC_W=24, COORD_W=13, and the state encoding.
REQ-032 One sub-module, bicubic_phase_acc (load, advance, init value, step -> int/frac), SHALL be instantiated twice, once for x and once for y.

Verification
REQ-033 Width=4, height=2, step=128, out_ready=1 -> (x_int, xBlend) = (-1,192), (0,64), (0,192), (1,64) per line; yBlend is 192 on row 0 and 64 on row 1; sol on pixels 0 and 4; eof on pixel 7; done 1 cycle later.
REQ-034 The same frame with out_ready toggled 1,0,0,1,... -> no sample is lost or duplicated and outputs are held during stalls.
REQ-035 Width=0 -> done pulses and out_valid never asserts.
REQ-036 step=0, width=2, height=1 -> behaves as step 256: (x_int, xBlend) = (0,0) then (1,0).
REQ-037 rst_n asserted at pixel 3 of a frame -> all outputs are 0 immediately; a new start then reproduces the REQ-033 sequence from pixel 0.
REQ-038 start pulsed mid-frame -> ignored, and the frame completes unchanged.
